// File: rtl/controle_jogo.sv
// Breakout game sequencer: match lifecycle, lives/blocks bookkeeping,
// serve/pause timing and start-key conditioning.
module controle_jogo #(
   parameter int LIVES        = 10,
   parameter int NUM_BLOCKS   = 40,
   parameter int SERVE_CYCLES = 25_000_000,
   parameter int PAUSE_CYCLES = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_n,
   input  logic       hit_block,
   input  logic       ball_lost,
   input  logic       blocks_bottom,
   output logic       start,
   output logic       freeze,
   output logic       ball_reset,
   output logic       show_over,
   output logic       show_win,
   output logic [3:0] lives_left,
   output logic [7:0] blocks_left,
   output logic [2:0] estado
);

   localparam int TMAX = (SERVE_CYCLES > PAUSE_CYCLES) ? SERVE_CYCLES : PAUSE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_CYCLES - 1);
   localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_CYCLES - 1);
   localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
   localparam logic [7:0]    BLOCK_INIT = 8'(NUM_BLOCKS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      LOST  = 3'd3,
      OVER  = 3'd4,
      WIN   = 3'd5
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic          key_s1;
   logic          key_s2;
   logic          key_prev;
   logic          press;
   logic [3:0]    lives_dec;
   logic [7:0]    blocks_dec;

   // Key synchronizer plus edge-history register; idle level is released (1)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_s1   <= 1'b1;
         key_s2   <= 1'b1;
         key_prev <= 1'b1;
      end else begin
         key_s1   <= key_n;
         key_s2   <= key_s1;
         key_prev <= key_s2;
      end
   end

   // A press is the falling edge of the synchronized key, one cycle wide
   assign press = key_prev & ~key_s2;

   // Saturating decrements of the game counters for this cycle's events
   assign lives_dec  = (ball_lost && lives_left != 4'd0) ? lives_left - 4'd1 : lives_left;
   assign blocks_dec = (hit_block && blocks_left != 8'd0) ? blocks_left - 8'd1 : blocks_left;

   // Match sequencer: state, counters, timer and the ball re-serve pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         timer       <= '0;
         ball_reset  <= 1'b0;
         lives_left  <= LIVES_INIT;
         blocks_left <= BLOCK_INIT;
      end else begin
         ball_reset <= 1'b0;
         case (state)
            IDLE: begin
               if (press) begin
                  lives_left  <= LIVES_INIT;
                  blocks_left <= BLOCK_INIT;
                  ball_reset  <= 1'b1;
                  timer       <= SERVE_LOAD;
                  state       <= SERVE;
               end
            end
            SERVE: begin
               if (blocks_bottom) begin
                  state <= OVER;
               end else if (timer == '0) begin
                  state <= PLAY;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            PLAY: begin
               if (blocks_bottom) begin
                  state <= OVER;
               end else begin
                  lives_left  <= lives_dec;
                  blocks_left <= blocks_dec;
                  if (hit_block && blocks_dec == 8'd0) begin
                     state <= WIN;
                  end else if (ball_lost) begin
                     if (lives_dec == 4'd0) begin
                        state <= OVER;
                     end else begin
                        timer <= PAUSE_LOAD;
                        state <= LOST;
                     end
                  end
               end
            end
            LOST: begin
               if (timer == '0) begin
                  ball_reset <= 1'b1;
                  timer      <= SERVE_LOAD;
                  state      <= SERVE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            OVER, WIN: begin
               if (press) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign start     = (state == PLAY);
   assign freeze    = (state != PLAY);
   assign show_over = (state == OVER);
   assign show_win  = (state == WIN);
   assign estado    = state;

endmodule

// File: tb/tb_controle_jogo.sv
// Self-checking bench for controle_jogo: directed match scenarios followed
// by randomized play, every cycle compared against a behavioural model.
module tb_controle_jogo;

   localparam int L  = 3;
   localparam int NB = 2;
   localparam int SC = 3;
   localparam int PC = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_n = 1'b1;
   logic       hit_block = 1'b0;
   logic       ball_lost = 1'b0;
   logic       blocks_bottom = 1'b0;
   logic       start;
   logic       freeze;
   logic       ball_reset;
   logic       show_over;
   logic       show_win;
   logic [3:0] lives_left;
   logic [7:0] blocks_left;
   logic [2:0] estado;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: match phase by code, counters, cycles left in phase
   int m_mode;
   int m_lives;
   int m_blocks;
   int m_left;
   int m_brst;
   logic kh[3];

   int nbr;
   int nserve;
   int nlost;

   controle_jogo #(
      .LIVES(L),
      .NUM_BLOCKS(NB),
      .SERVE_CYCLES(SC),
      .PAUSE_CYCLES(PC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_n(key_n),
      .hit_block(hit_block),
      .ball_lost(ball_lost),
      .blocks_bottom(blocks_bottom),
      .start(start),
      .freeze(freeze),
      .ball_reset(ball_reset),
      .show_over(show_over),
      .show_win(show_win),
      .lives_left(lives_left),
      .blocks_left(blocks_left),
      .estado(estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_lives  = L;
      m_blocks = NB;
      m_left   = 0;
      m_brst   = 0;
      kh[0] = 1'b1;
      kh[1] = 1'b1;
      kh[2] = 1'b1;
   endtask

   // one rising edge of the game rules, using the inputs present at the edge
   task automatic model_step();
      logic pr;
      pr = kh[2] & ~kh[1];
      kh[2] = kh[1];
      kh[1] = kh[0];
      kh[0] = key_n;
      m_brst = 0;
      case (m_mode)
         0: if (pr) begin
               m_lives  = L;
               m_blocks = NB;
               m_brst   = 1;
               m_left   = SC;
               m_mode   = 1;
            end
         1: if (blocks_bottom) m_mode = 4;
            else begin
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         2: if (blocks_bottom) m_mode = 4;
            else begin
               if (hit_block && m_blocks > 0) m_blocks--;
               if (ball_lost && m_lives > 0) m_lives--;
               if (hit_block && m_blocks == 0) m_mode = 5;
               else if (ball_lost) begin
                  if (m_lives == 0) m_mode = 4;
                  else begin
                     m_mode = 3;
                     m_left = PC;
                  end
               end
            end
         3: begin
               m_left--;
               if (m_left == 0) begin
                  m_brst = 1;
                  m_left = SC;
                  m_mode = 1;
               end
            end
         default: if (pr) m_mode = 0;
      endcase
   endtask

   task automatic check_all();
      chk("estado", estado, m_mode);
      chk("start", start, m_mode == 2);
      chk("freeze", freeze, m_mode != 2);
      chk("show_over", show_over, m_mode == 4);
      chk("show_win", show_win, m_mode == 5);
      chk("ball_reset", ball_reset, m_brst);
      chk("lives_left", lives_left, m_lives);
      chk("blocks_left", blocks_left, m_blocks);
      chk("start_freeze_excl", start & freeze, 0);
   endtask

   task automatic cyc(input logic k, input logic h, input logic l, input logic b);
      key_n = k;
      hit_block = h;
      ball_lost = l;
      blocks_bottom = b;
      @(posedge clock);
      model_step();
      #1;
      check_all();
      if (ball_reset === 1'b1) nbr++;
      if (estado === 3'd1) nserve++;
      if (estado === 3'd3) nlost++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_key();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      idle_n(4);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   task automatic wait_mode(input int code, input int limit);
      int n;
      n = 0;
      while (m_mode != code && n < limit) begin
         idle_n(1);
         n++;
      end
      chk("reach_state", estado, code);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;
      idle_n(4);

      do_reset();
      chk("rst_lives", lives_left, 3);
      chk("rst_blocks", blocks_left, 2);
      chk("rst_freeze", freeze, 1);

      nbr = 0;
      nserve = 0;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      wait_mode(2, 20);
      chk("first_press_pulses", nbr, 1);
      chk("serve_len", nserve, 3);
      chk("play_start", start, 1);
      idle_n(3);

      nlost = 0;
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("lost_lives", lives_left, 2);
      wait_mode(2, 20);
      chk("lost_len", nlost, 4);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      wait_mode(2, 20);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("over_flag", show_over, 1);
      chk("over_lives", lives_left, 0);
      chk("over_start", start, 0);

      press_key();
      chk("over_to_idle", estado, 0);
      press_key();
      wait_mode(2, 20);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("win_blk1", blocks_left, 1);
      idle_n(1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("win_flag", show_win, 1);
      chk("win_blk0", blocks_left, 0);

      press_key();
      press_key();
      wait_mode(2, 20);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("simul_win", estado, 5);
      chk("simul_win_lives", lives_left, 2);

      press_key();
      press_key();
      wait_mode(2, 20);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("simul_lost_blk", blocks_left, 1);
      chk("simul_lost_lives", lives_left, 2);
      chk("simul_lost_state", estado, 3);

      wait_mode(1, 20);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("bottom_serve", estado, 4);
      press_key();
      chk("bottom_idle", estado, 0);
      press_key();
      wait_mode(2, 20);
      chk("rematch_lives", lives_left, 3);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle_n(2);
      do_reset();
      chk("lost_rst_state", estado, 0);
      chk("lost_rst_brst", ball_reset, 0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            logic k;
            k = key_n;
            if ($urandom_range(0, 19) == 0) k = ~k;
            cyc(k,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
